// File: rtl/br_pkg.sv
// Shared definitions for the D-stage branch sequencer: one-hot op codes, FSM encodings
// and the helper that tells which ops compare against rt.
package br_pkg;

  localparam int CNT_W = 8;

  localparam logic [5:0] BR_BEQ  = 6'b100000;
  localparam logic [5:0] BR_BGEZ = 6'b010000;
  localparam logic [5:0] BR_BGTZ = 6'b001000;
  localparam logic [5:0] BR_BLEZ = 6'b000100;
  localparam logic [5:0] BR_BLTZ = 6'b000010;
  localparam logic [5:0] BR_BNE  = 6'b000001;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_REDIR = 2'd2
  } br_state_t;

  // Only BEQ and BNE read rt; the single-operand compares ignore rt_ready.
  function automatic logic need_rt(input logic [5:0] op);
    return op[5] | op[0];
  endfunction

endpackage

// File: rtl/br_wait_counter.sv
// Saturating count of operand-wait cycles with a sticky timeout flag.
// Latency: count and flag update on the edge after start/inc; flag clears only on reset.
module br_wait_counter
  import br_pkg::*;
#(
  parameter int WAIT_LIMIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic i_start,
  input  logic i_inc,
  output logic o_timeout
);

  localparam logic [CNT_W-1:0] LIM = CNT_W'(WAIT_LIMIT);

  logic [CNT_W-1:0] r_cnt;
  logic             r_timeout;
  logic             w_hit;

  // Flag sets on the same edge the count lands on the limit.
  assign w_hit = (i_start & (LIM == CNT_W'(1))) |
                 (i_inc & (r_cnt == LIM - CNT_W'(1)));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (i_start) begin
        r_cnt <= CNT_W'(1);
      end else if (i_inc) begin
        if (r_cnt != LIM) r_cnt <= r_cnt + CNT_W'(1);
      end else begin
        r_cnt <= '0;
      end
      if (w_hit) r_timeout <= 1'b1;
    end
  end

  assign o_timeout = r_timeout;

endmodule

// File: rtl/branch_resolve_ctrl.sv
// D-stage branch sequencer: waits for operands, fires the comparator once, pulses resolved/redirect.
// Latency 1 cycle from resolve to resolved/redirect; stalls F/D while operands wait. BR_STATS_EN adds counters.
module branch_resolve_ctrl
  import br_pkg::*;
#(
  parameter int WAIT_LIMIT = 16,
  parameter int PC_W       = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            br_valid,
  input  logic [5:0]      br_op,
  input  logic [PC_W-1:0] br_target,
  input  logic            rs_ready,
  input  logic            rt_ready,
  output logic            cmp_branch,
  output logic [5:0]      cmp_bop,
  input  logic            cmp_check,
  output logic            stall_d,
  output logic            resolved,
  output logic            taken,
  output logic            redirect_valid,
  output logic [PC_W-1:0] redirect_pc,
  output logic            wait_timeout
`ifdef BR_STATS_EN
  ,
  output logic [31:0]     stat_resolved,
  output logic [31:0]     stat_taken,
  output logic [31:0]     stat_stall
`endif
);

  br_state_t       r_state, w_next;
  logic            r_resolved, r_taken;
  logic [PC_W-1:0] r_redirect_pc;
  logic            w_ready, w_resolve, w_cmp_en, w_taken, w_in_redir;
  logic            w_wait_start, w_wait_inc;

  assign w_in_redir = (r_state == S_REDIR);
  assign w_ready    = rs_ready & (rt_ready | ~need_rt(br_op));
  assign w_resolve  = ~w_in_redir & br_valid & w_ready & ~flush;
  // A malformed op still resolves, but never fires the comparator and is never taken.
  assign w_cmp_en   = w_resolve & $onehot(br_op);
  assign w_taken    = w_cmp_en & cmp_check;

  assign w_wait_start = (r_state == S_IDLE) & br_valid & ~w_ready & ~flush;
  assign w_wait_inc   = (r_state == S_WAIT) & br_valid & ~w_ready & ~flush;

  always_comb begin
    w_next = r_state;
    if (flush) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (w_resolve) w_next = w_taken ? S_REDIR : S_IDLE;
                 else if (w_wait_start) w_next = S_WAIT;
        S_WAIT:  if (w_resolve) w_next = w_taken ? S_REDIR : S_IDLE;
                 else if (!br_valid) w_next = S_IDLE;
        S_REDIR: w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_resolved    <= 1'b0;
      r_taken       <= 1'b0;
      r_redirect_pc <= '0;
    end else begin
      r_state    <= w_next;
      r_resolved <= w_resolve;
      r_taken    <= w_taken;
      if (w_resolve) r_redirect_pc <= br_target;
    end
  end

  br_wait_counter #(.WAIT_LIMIT(WAIT_LIMIT)) u_wait (
    .clk       (clk),
    .reset     (reset),
    .i_start   (w_wait_start),
    .i_inc     (w_wait_inc),
    .o_timeout (wait_timeout)
  );

  assign cmp_branch     = w_cmp_en;
  assign cmp_bop        = w_cmp_en ? br_op : 6'b0;
  assign stall_d        = br_valid & ~flush & ((~w_in_redir & ~w_ready) | w_in_redir);
  assign resolved       = r_resolved;
  assign taken          = r_taken;
  // A flush landing in the redirect cycle kills the redirect combinationally.
  assign redirect_valid = w_in_redir & ~flush;
  assign redirect_pc    = r_redirect_pc;

`ifdef BR_STATS_EN
  logic [31:0] r_stat_resolved, r_stat_taken, r_stat_stall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stat_resolved <= '0;
      r_stat_taken    <= '0;
      r_stat_stall    <= '0;
    end else begin
      if (w_resolve) r_stat_resolved <= r_stat_resolved + 32'd1;
      if (w_taken)   r_stat_taken    <= r_stat_taken + 32'd1;
      if (stall_d)   r_stat_stall    <= r_stat_stall + 32'd1;
    end
  end

  assign stat_resolved = r_stat_resolved;
  assign stat_taken    = r_stat_taken;
  assign stat_stall    = r_stat_stall;
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed bench for branch_resolve_ctrl with WAIT_LIMIT=4; stats checks appear when BR_STATS_EN is defined.
module tb_branch_resolve_ctrl;
  import br_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        flush, br_valid, rs_ready, rt_ready, cmp_check;
  logic [5:0]  br_op;
  logic [31:0] br_target;
  logic        cmp_branch, stall_d, resolved, taken, redirect_valid, wait_timeout;
  logic [5:0]  cmp_bop;
  logic [31:0] redirect_pc;
`ifdef BR_STATS_EN
  logic [31:0] stat_resolved, stat_taken, stat_stall;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  branch_resolve_ctrl #(.WAIT_LIMIT(4), .PC_W(32)) dut (
    .clk(clk), .reset(reset), .flush(flush), .br_valid(br_valid), .br_op(br_op),
    .br_target(br_target), .rs_ready(rs_ready), .rt_ready(rt_ready),
    .cmp_branch(cmp_branch), .cmp_bop(cmp_bop), .cmp_check(cmp_check), .stall_d(stall_d),
    .resolved(resolved), .taken(taken), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .wait_timeout(wait_timeout)
`ifdef BR_STATS_EN
    , .stat_resolved(stat_resolved), .stat_taken(stat_taken), .stat_stall(stat_stall)
`endif
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in;
    flush = 1'b0; br_valid = 1'b0; br_op = 6'b0; br_target = 32'h0;
    rs_ready = 1'b1; rt_ready = 1'b1; cmp_check = 1'b0;
  endtask

  task automatic test_reset;
    idle_in();
    #12;
    n_tests++; if ({resolved, taken, redirect_valid, wait_timeout, stall_d, cmp_branch} !== 6'b0) begin n_fail++; $display("FAIL reset_flags got %b exp 000000", {resolved, taken, redirect_valid, wait_timeout, stall_d, cmp_branch}); end
    n_tests++; if (redirect_pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc got %h exp 0", redirect_pc); end
    reset = 1'b1;
    step();
  endtask

  task automatic test_beq_taken;
    br_valid = 1'b1; br_op = BR_BEQ; br_target = 32'h0000_3010; cmp_check = 1'b1;
    #1;
    n_tests++; if (cmp_branch !== 1'b1 || stall_d !== 1'b0) begin n_fail++; $display("FAIL t1_cmp got cmp=%b stall=%b exp cmp=1 stall=0", cmp_branch, stall_d); end
    n_tests++; if (cmp_bop !== BR_BEQ) begin n_fail++; $display("FAIL t1_bop got %b exp %b", cmp_bop, BR_BEQ); end
    step(); idle_in(); #1;
    n_tests++; if ({resolved, taken, redirect_valid} !== 3'b111) begin n_fail++; $display("FAIL t1_result got %b exp 111", {resolved, taken, redirect_valid}); end
    n_tests++; if (redirect_pc !== 32'h0000_3010) begin n_fail++; $display("FAIL t1_pc got %h exp 00003010", redirect_pc); end
    step();
    n_tests++; if ({resolved, redirect_valid} !== 2'b00) begin n_fail++; $display("FAIL t1_pulse got %b exp 00", {resolved, redirect_valid}); end
  endtask

  task automatic test_bne_wait;
    br_valid = 1'b1; br_op = BR_BNE; br_target = 32'h0000_2000; rt_ready = 1'b0; cmp_check = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_tests++; if (stall_d !== 1'b1 || cmp_branch !== 1'b0) begin n_fail++; $display("FAIL t2_stall%0d got stall=%b cmp=%b exp 1 0", i, stall_d, cmp_branch); end
      step();
    end
    rt_ready = 1'b1; #1;
    n_tests++; if (stall_d !== 1'b0 || cmp_branch !== 1'b1) begin n_fail++; $display("FAIL t2_fire got stall=%b cmp=%b exp 0 1", stall_d, cmp_branch); end
    step(); idle_in(); #1;
    n_tests++; if ({resolved, taken, redirect_valid} !== 3'b100) begin n_fail++; $display("FAIL t2_result got %b exp 100", {resolved, taken, redirect_valid}); end
    n_tests++; if (wait_timeout !== 1'b0) begin n_fail++; $display("FAIL t2_timeout got %b exp 0", wait_timeout); end
`ifdef BR_STATS_EN
    n_tests++; if ({stat_resolved, stat_taken, stat_stall} !== {32'd2, 32'd1, 32'd3}) begin n_fail++; $display("FAIL stats got %0d %0d %0d exp 2 1 3", stat_resolved, stat_taken, stat_stall); end
`endif
    step();
    n_tests++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL t2_noredir got %b exp 0", redirect_valid); end
  endtask

  task automatic test_bgez_rt_ignored;
    br_valid = 1'b1; br_op = BR_BGEZ; br_target = 32'h0000_0040; rt_ready = 1'b0; cmp_check = 1'b1;
    #1;
    n_tests++; if (stall_d !== 1'b0 || cmp_branch !== 1'b1) begin n_fail++; $display("FAIL t3_fire got stall=%b cmp=%b exp 0 1", stall_d, cmp_branch); end
    step(); idle_in(); #1;
    n_tests++; if ({resolved, taken, redirect_valid} !== 3'b111 || redirect_pc !== 32'h40) begin n_fail++; $display("FAIL t3_result got %b pc=%h exp 111 pc=40", {resolved, taken, redirect_valid}, redirect_pc); end
    step();
  endtask

  task automatic test_flush;
    br_valid = 1'b1; br_op = BR_BEQ; br_target = 32'h0000_0080; cmp_check = 1'b1;
    step(); idle_in(); flush = 1'b1; #1;
    n_tests++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL t5_redir_flush got %b exp 0", redirect_valid); end
    step(); flush = 1'b0; #1;
    n_tests++; if (dut.r_state !== S_IDLE || redirect_valid !== 1'b0) begin n_fail++; $display("FAIL t5_idle got state=%0d rv=%b exp 0 0", dut.r_state, redirect_valid); end
    br_valid = 1'b1; br_op = BR_BNE; rt_ready = 1'b0;
    step(); step();
    flush = 1'b1; #1;
    n_tests++; if (stall_d !== 1'b0 || cmp_branch !== 1'b0) begin n_fail++; $display("FAIL t5_wait_flush got stall=%b cmp=%b exp 0 0", stall_d, cmp_branch); end
    step(); idle_in(); #1;
    n_tests++; if (resolved !== 1'b0 || dut.r_state !== S_IDLE) begin n_fail++; $display("FAIL t5_noresolve got res=%b state=%0d exp 0 0", resolved, dut.r_state); end
    step();
  endtask

  task automatic test_bad_op;
    br_valid = 1'b1; br_op = 6'b110000; br_target = 32'h0000_0100; cmp_check = 1'b1;
    #1;
    n_tests++; if (cmp_branch !== 1'b0 || cmp_bop !== 6'b0 || stall_d !== 1'b0) begin n_fail++; $display("FAIL t6_cmp got cmp=%b bop=%b stall=%b exp 0 000000 0", cmp_branch, cmp_bop, stall_d); end
    step(); idle_in(); #1;
    n_tests++; if ({resolved, taken, redirect_valid} !== 3'b100) begin n_fail++; $display("FAIL t6_result got %b exp 100", {resolved, taken, redirect_valid}); end
    step();
  endtask

  task automatic test_back_to_back;
    br_valid = 1'b1; br_op = BR_BEQ; br_target = 32'h0000_0200; cmp_check = 1'b1;
    step();
    br_op = BR_BNE; br_target = 32'h0000_0300; cmp_check = 1'b0; #1;
    n_tests++; if ({stall_d, cmp_branch, redirect_valid, resolved} !== 4'b1011) begin n_fail++; $display("FAIL bb_slot got %b exp 1011", {stall_d, cmp_branch, redirect_valid, resolved}); end
    step(); #1;
    n_tests++; if ({stall_d, cmp_branch, redirect_valid} !== 3'b010) begin n_fail++; $display("FAIL bb_fire got %b exp 010", {stall_d, cmp_branch, redirect_valid}); end
    step(); idle_in(); #1;
    n_tests++; if ({resolved, taken, redirect_valid} !== 3'b100 || redirect_pc !== 32'h300) begin n_fail++; $display("FAIL bb_result got %b pc=%h exp 100 pc=300", {resolved, taken, redirect_valid}, redirect_pc); end
    step();
  endtask

  task automatic test_timeout;
    br_valid = 1'b1; br_op = BR_BEQ; br_target = 32'h0000_0400; rs_ready = 1'b0; cmp_check = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      n_tests++; if (wait_timeout !== (i >= 3)) begin n_fail++; $display("FAIL t4_wait%0d got %b exp %b", i, wait_timeout, (i >= 3)); end
    end
    rs_ready = 1'b1;
    step(); idle_in(); #1;
    n_tests++; if (resolved !== 1'b1 || wait_timeout !== 1'b1) begin n_fail++; $display("FAIL t4_resolve got res=%b to=%b exp 1 1", resolved, wait_timeout); end
    step(); step();
    n_tests++; if (wait_timeout !== 1'b1) begin n_fail++; $display("FAIL t4_sticky got %b exp 1", wait_timeout); end
  endtask

  task automatic test_async_reset;
    br_valid = 1'b1; br_op = BR_BEQ; br_target = 32'h0000_0500; cmp_check = 1'b1;
    step(); idle_in(); #2;
    reset = 1'b0; #1;
    n_tests++; if ({resolved, taken, redirect_valid, wait_timeout} !== 4'b0) begin n_fail++; $display("FAIL arst_flags got %b exp 0000", {resolved, taken, redirect_valid, wait_timeout}); end
    n_tests++; if (dut.r_state !== S_IDLE || redirect_pc !== 32'h0) begin n_fail++; $display("FAIL arst_state got state=%0d pc=%h exp 0 0", dut.r_state, redirect_pc); end
    reset = 1'b1;
    step(); step();
    n_tests++; if (redirect_valid !== 1'b0 || resolved !== 1'b0) begin n_fail++; $display("FAIL arst_after got rv=%b res=%b exp 0 0", redirect_valid, resolved); end
  endtask

  initial begin
    test_reset();
    test_beq_taken();
    test_bne_wait();
    test_bgez_rt_ignored();
    test_flush();
    test_bad_op();
    test_back_to_back();
    test_timeout();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
